aibcr3aux_osc_freqmon: RTL and testbench

- Parametrised successor to the aux oscillator monitor.
- Replaces fixed divide-by-16/32/64 taps with one programmable power-of-two monitor divider.
- Adds a windowed event-count engine: counts rising edges of an asynchronous event input (e.g. comparator output) over a programmable number of oscillator cycles, with start/busy/done handshake.
- Sits on the oscillator clock domain, after the clock-gate sync stage; feeds oosc_monitor and DFT status.

---
 rtl/aibcr3aux_osc_freqmon_pkg.sv | 27 ++
 rtl/aibcr3aux_osc_freqmon_sync.sv | 34 +++
 rtl/aibcr3aux_osc_freqmon.sv | 146 ++++++++++++++
 tb/tb_aibcr3aux_osc_freqmon.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3aux_osc_freqmon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aibcr3aux_osc_freqmon_pkg
// Brief   : Shared types, defaults and helpers for the aux oscillator monitor.
// Revision: 1.0 - initial release
// ============================================================================
package aibcr3aux_osc_freqmon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } meas_state_e;

    localparam int c_DEF_DIV_W       = 8;
    localparam int c_DEF_SEL_W       = 3;
    localparam int c_DEF_WIN_W       = 16;
    localparam int c_DEF_CNT_W       = 12;
    localparam int c_DEF_SYNC_STAGES = 2;

    // Limits a requested divider tap to the highest bit the counter has.
    function automatic int clamp_sel(input int sel, input int max_sel);
        return (sel > max_sel) ? max_sel : sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aibcr3aux_osc_freqmon_sync.sv
`default_nettype none
// ============================================================================
// Module  : aibcr3aux_osc_freqmon_sync
// Brief   : Multi-flop synchroniser for the async event input + rise detect.
// Revision: 1.0 - initial release
// ============================================================================
module aibcr3aux_osc_freqmon_sync
    import aibcr3aux_osc_freqmon_pkg::*;
#(
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  logic clkin,
    input  logic irst,
    input  logic ievent,
    output logic oedge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clkin) begin
        if (irst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ievent};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign oedge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/aibcr3aux_osc_freqmon.sv
`default_nettype none
// ============================================================================
// Module  : aibcr3aux_osc_freqmon
// Brief   : Programmable power-of-two monitor divider plus windowed event counter.
// Revision: 1.0 - initial release
// ============================================================================
module aibcr3aux_osc_freqmon
    import aibcr3aux_osc_freqmon_pkg::*;
#(
    parameter int DIV_W       = c_DEF_DIV_W,
    parameter int SEL_W       = c_DEF_SEL_W,
    parameter int WIN_W       = c_DEF_WIN_W,
    parameter int CNT_W       = c_DEF_CNT_W,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  logic             clkin,
    input  logic             irst,
    input  logic             imon_en,
    input  logic [SEL_W-1:0] idiv_sel,
    output logic             omon_clk,
    input  logic             imeas_start,
    input  logic [WIN_W-1:0] imeas_win,
    input  logic             ievent,
    output logic             omeas_busy,
    output logic             omeas_done,
    output logic [CNT_W-1:0] omeas_count,
    output logic             omeas_ovf
);

    localparam int c_SELQ_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;

    logic [DIV_W-1:0]    r_div_cnt;
    logic [c_SELQ_W-1:0] r_sel_q;
    logic                r_en_q;
    logic                r_mon_clk;
    logic                w_sel_load;
    logic [c_SELQ_W-1:0] w_sel_clamped;

    // Tap changes only take effect at counter wrap so no runt pulse escapes.
    assign w_sel_load    = imon_en & (~r_en_q | (&r_div_cnt));
    assign w_sel_clamped = c_SELQ_W'(clamp_sel(int'(idiv_sel), DIV_W - 1));

    always_ff @(posedge clkin) begin
        if (irst) begin
            r_div_cnt <= '0;
            r_sel_q   <= '0;
            r_en_q    <= 1'b0;
            r_mon_clk <= 1'b0;
        end else begin
            r_en_q <= imon_en;
            if (imon_en) begin
                r_div_cnt <= r_div_cnt + 1'b1;
                r_mon_clk <= r_div_cnt[r_sel_q];
            end else begin
                r_div_cnt <= '0;
                r_mon_clk <= 1'b0;
            end
            if (w_sel_load) begin
                r_sel_q <= w_sel_clamped;
            end
        end
    end

    assign omon_clk = r_mon_clk;

    logic w_event_edge;

    aibcr3aux_osc_freqmon_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clkin  (clkin),
        .irst   (irst),
        .ievent (ievent),
        .oedge  (w_event_edge)
    );

    meas_state_e       r_state;
    meas_state_e       w_state_nxt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    always_ff @(posedge clkin) begin
        if (irst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (imeas_start) begin
                    w_state_nxt = (imeas_win != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                if (r_win_cnt == WIN_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window and event-count datapath; a start in COUNT is deliberately ignored.
    always_ff @(posedge clkin) begin
        if (irst) begin
            r_win_cnt <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (imeas_start) begin
                        r_win_cnt <= imeas_win;
                        r_count   <= '0;
                        r_ovf     <= 1'b0;
                    end
                end
                COUNT: begin
                    r_win_cnt <= r_win_cnt - 1'b1;
                    if (w_event_edge) begin
                        if (&r_count) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        omeas_busy  = (r_state == COUNT);
        omeas_done  = (r_state == DONE);
        omeas_count = r_count;
        omeas_ovf   = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_aibcr3aux_osc_freqmon.sv
`default_nettype none
// ============================================================================
// Module  : tb_aibcr3aux_osc_freqmon
// Brief   : Directed self-checking bench for the aux oscillator monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aibcr3aux_osc_freqmon;

    logic        clk = 1'b0;
    logic        rst;
    logic        mon_en;
    logic [2:0]  div_sel;
    logic        meas_start;
    logic [15:0] meas_win;
    logic        event_in;

    logic        mon_clk, busy, done, ovf;
    logic [11:0] count;
    logic        mon_clk4, busy4, done4, ovf4;
    logic [3:0]  count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aibcr3aux_osc_freqmon u_dut (
        .clkin       (clk),
        .irst        (rst),
        .imon_en     (mon_en),
        .idiv_sel    (div_sel),
        .omon_clk    (mon_clk),
        .imeas_start (meas_start),
        .imeas_win   (meas_win),
        .ievent      (event_in),
        .omeas_busy  (busy),
        .omeas_done  (done),
        .omeas_count (count),
        .omeas_ovf   (ovf)
    );

    aibcr3aux_osc_freqmon #(.CNT_W(4)) u_dut4 (
        .clkin       (clk),
        .irst        (rst),
        .imon_en     (mon_en),
        .idiv_sel    (div_sel),
        .omon_clk    (mon_clk4),
        .imeas_start (meas_start),
        .imeas_win   (meas_win),
        .ievent      (event_in),
        .omeas_busy  (busy4),
        .omeas_done  (done4),
        .omeas_count (count4),
        .omeas_ovf   (ovf4)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mon_en = 1'b0; div_sel = 3'd0;
        meas_start = 1'b0; meas_win = 16'd0; event_in = 1'b0;
        cyc; cyc;
        rst = 1'b0;
        n_checks++; if (mon_clk !== 1'b0) begin n_fail++; $display("FAIL reset_mon_clk got %0b want 0", mon_clk); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        n_checks++; if (count4 !== 4'd0 || ovf4 !== 1'b0) begin n_fail++; $display("FAIL reset_dut4 got count=%0d ovf=%0b want 0/0", count4, ovf4); end
    endtask

    // Divide by 16, then switch to divide by 2 while the count is 5.
    task automatic test_divider;
        int act;
        int first_rise;
        logic exp;
        mon_en = 1'b1; div_sel = 3'd3; act = 3; first_rise = -1;
        for (int j = 0; j < 300; j++) begin
            cyc;
            exp = (((j % 256) >> act) & 1) != 0;
            n_checks++;
            if (mon_clk !== exp) begin
                n_fail++;
                $display("FAIL divider_wave cycle %0d got %0b want %0b", j, mon_clk, exp);
            end
            if (first_rise < 0 && mon_clk === 1'b1) first_rise = j;
            if ((j % 256) == 255) act = int'(div_sel);
            if (j == 4) div_sel = 3'd0;
        end
        n_checks++; if (first_rise != 8) begin n_fail++; $display("FAIL divider_first_rise got %0d want 8", first_rise); end
        mon_en = 1'b0;
        cyc;
        n_checks++; if (mon_clk !== 1'b0) begin n_fail++; $display("FAIL divider_disable got %0b want 0", mon_clk); end
        cyc;
        n_checks++; if (mon_clk !== 1'b0) begin n_fail++; $display("FAIL divider_disable_hold got %0b want 0", mon_clk); end
    endtask

    task automatic test_window;
        int busy_hi;
        meas_start = 1'b1; meas_win = 16'd100;
        cyc;
        meas_start = 1'b0;
        busy_hi = (busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 100; k++) begin
            event_in = ((k / 10) % 2) == 1;
            cyc;
            if (busy === 1'b1) busy_hi++;
        end
        event_in = 1'b0;
        n_checks++; if (busy_hi != 100) begin n_fail++; $display("FAIL window_busy_cycles got %0d want 100", busy_hi); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL window_done got done=%0b busy=%0b want 1/0", done, busy); end
        n_checks++; if (count !== 12'd5) begin n_fail++; $display("FAIL window_count got %0d want 5", count); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL window_ovf got %0b want 0", ovf); end
        n_checks++; if (count4 !== 4'd5) begin n_fail++; $display("FAIL window_count4 got %0d want 5", count4); end
    endtask

    task automatic test_saturation;
        meas_start = 1'b1; meas_win = 16'd200;
        cyc;
        meas_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            event_in = ((k / 4) % 2) == 1;
            cyc;
        end
        event_in = 1'b0;
        n_checks++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL sat_done got %0b want 1", done4); end
        n_checks++; if (count4 !== 4'd15) begin n_fail++; $display("FAIL sat_count got %0d want 15", count4); end
        n_checks++; if (ovf4 !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got %0b want 1", ovf4); end
        n_checks++; if (count !== 12'd25 || ovf !== 1'b0) begin n_fail++; $display("FAIL sat_wide_count got %0d ovf=%0b want 25/0", count, ovf); end
    endtask

    task automatic test_zero_window;
        meas_start = 1'b1; meas_win = 16'd0;
        cyc;
        meas_start = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_win_done got done=%0b busy=%0b want 1/0", done, busy); end
        n_checks++; if (count !== 12'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL zero_win_count got %0d ovf=%0b want 0/0", count, ovf); end
        n_checks++; if (count4 !== 4'd0 || ovf4 !== 1'b0) begin n_fail++; $display("FAIL zero_win_dut4 got %0d ovf=%0b want 0/0", count4, ovf4); end
    endtask

    task automatic test_start_during_count;
        meas_start = 1'b1; meas_win = 16'd20;
        cyc;
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                meas_start = 1'b1; meas_win = 16'd3;
            end else begin
                meas_start = 1'b0;
            end
            cyc;
            if (k == 8) begin
                n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL ignore_start_k8 got busy=%0b done=%0b want 1/0", busy, done); end
            end
            if (k == 19) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_start_k19 got busy=%0b want 1", busy); end
            end
            if (k == 20) begin
                n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_end got done=%0b busy=%0b want 1/0", done, busy); end
            end
        end
        meas_start = 1'b0;
    endtask

    task automatic test_reset_mid;
        meas_start = 1'b1; meas_win = 16'd100;
        cyc;
        meas_start = 1'b0;
        for (int k = 0; k < 49; k++) begin
            event_in = (k >= 10);
            cyc;
        end
        event_in = 1'b0;
        n_checks++; if (busy !== 1'b1 || count !== 12'd1) begin n_fail++; $display("FAIL mid_pre_reset got busy=%0b count=%0d want 1/1", busy, count); end
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags got busy=%0b done=%0b want 0/0", busy, done); end
        n_checks++; if (count !== 12'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_count got %0d ovf=%0b want 0/0", count, ovf); end
        cyc;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_done got done=%0b busy=%0b want 0/0", done, busy); end
    endtask

    // Edge detect fires in the single sampled cycle of a win=1 restart.
    task automatic test_back_to_back;
        meas_start = 1'b1; meas_win = 16'd0;
        cyc;
        meas_start = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_setup_done got %0b want 1", done); end
        event_in = 1'b1;
        cyc;
        meas_start = 1'b1; meas_win = 16'd1;
        cyc;
        meas_start = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_done_drop got done=%0b busy=%0b want 0/1", done, busy); end
        cyc;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_rise got done=%0b busy=%0b want 1/0", done, busy); end
        n_checks++; if (count !== 12'd1 || count4 !== 4'd1) begin n_fail++; $display("FAIL b2b_count got %0d/%0d want 1/1", count, count4); end
        event_in = 1'b0;
    endtask

    initial begin
        test_reset;
        test_divider;
        test_window;
        test_saturation;
        test_zero_window;
        test_start_during_count;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
